// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: state encoding, default wait
// states and the strobe decode used to register the chip pins.
package sram_ctrl_pkg;

    localparam int RD_WAIT_DEFAULT = 1;
    localparam int WR_WAIT_DEFAULT = 1;
    localparam int WAIT_CNT_WIDTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Chip-side control bundle; all fields are active as named (drive = 1 owns the bus).
    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic we_n;
        logic drive;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{cs_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

    // Pin levels the chip sees while the controller sits in state s.
    // OE and WE are never both low, and the bus is only driven when OE is high.
    function automatic strobe_t decode_strobes(input state_t s);
        strobe_t st;
        st = STROBE_IDLE;
        case (s)
            ST_READ: begin
                st.cs_n = 1'b0;
                st.oe_n = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                st.cs_n  = 1'b0;
                st.drive = 1'b1;
            end
            ST_WR_PULSE: begin
                st.cs_n  = 1'b0;
                st.we_n  = 1'b0;
                st.drive = 1'b1;
            end
            default: ;
        endcase
        return st;
    endfunction

    // Wait-state parameter narrowed to the counter width.
    function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load(input int cycles);
        return WAIT_CNT_WIDTH'(cycles);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/acknowledge bus of the SRAM controller.
interface sram_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;
    logic                  busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that times the READ and WR_PULSE phases.
module sram_wait_timer
    import sram_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      load,
    input  logic [WAIT_CNT_WIDTH-1:0] load_val,
    input  logic                      dec,
    output logic                      zero
);
    logic [WAIT_CNT_WIDTH-1:0] count_reg;

    // Load on phase entry, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);
endmodule

// File: rtl/sram_ctrl.sv
// Synchronous req/ack front end for an asynchronous active-low SRAM.
// Every chip pin comes straight from a flop: strobes are decoded from the
// next state and registered, so they line up with the state they belong to.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WAIT    = RD_WAIT_DEFAULT,
    parameter int WR_WAIT    = WR_WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_ctrl_if.slave            bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_notOE,
    output logic                  sram_notWE,
    output logic                  sram_notCS
);
    state_t                    state_reg, state_next;
    strobe_t                   strobe_reg;
    logic                      timer_load, timer_dec, timer_zero;
    logic [WAIT_CNT_WIDTH-1:0] timer_val;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg, rdata_reg;
    logic                      ack_reg, busy_reg;

    sram_wait_timer u_timer (
        .clk      (clk),
        .srst     (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Next-state logic; the timer is loaded on entry to each timed phase.
    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        timer_dec  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    if (bus.we) begin
                        state_next = ST_WR_SETUP;
                    end else begin
                        state_next = ST_READ;
                        timer_load = 1'b1;
                        timer_val  = wait_load(RD_WAIT);
                    end
                end
            end
            ST_READ: begin
                if (timer_zero) state_next = ST_DONE;
                else            timer_dec  = 1'b1;
            end
            ST_WR_SETUP: begin
                state_next = ST_WR_PULSE;
                timer_load = 1'b1;
                timer_val  = wait_load(WR_WAIT);
            end
            ST_WR_PULSE: begin
                if (timer_zero) state_next = ST_WR_HOLD;
                else            timer_dec  = 1'b1;
            end
            ST_WR_HOLD: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State, strobes and status flags, all registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            strobe_reg <= STROBE_IDLE;
            ack_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            strobe_reg <= decode_strobes(state_next);
            ack_reg    <= (state_next == ST_DONE);
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    // Request latch and read-data capture on the last READ edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && bus.req) begin
                addr_reg  <= bus.addr;
                wdata_reg <= bus.wdata;
            end
            if ((state_reg == ST_READ) && timer_zero) begin
                rdata_reg <= sram_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bus_drv
            assign sram_data[gi] = strobe_reg.drive ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

    assign sram_addr  = addr_reg;
    assign sram_notCS = strobe_reg.cs_n;
    assign sram_notOE = strobe_reg.oe_n;
    assign sram_notWE = strobe_reg.we_n;
    assign bus.rdata  = rdata_reg;
    assign bus.ack    = ack_reg;
    assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance with RD_WAIT=1/WR_WAIT=2 and one
// with both waits at 0, each wired to a small behavioural async SRAM.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    logic [AW-1:0] sa_addr, sb_addr;
    wire  [DW-1:0] sa_data, sb_data;
    logic          a_oe, a_we, a_cs, b_oe, b_we, b_cs;

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(1), .WR_WAIT(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave),
        .sram_addr(sa_addr), .sram_data(sa_data),
        .sram_notOE(a_oe), .sram_notWE(a_we), .sram_notCS(a_cs)
    );

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(0), .WR_WAIT(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave),
        .sram_addr(sb_addr), .sram_data(sb_data),
        .sram_notOE(b_oe), .sram_notWE(b_we), .sram_notCS(b_cs)
    );

    // Behavioural SRAMs: drive data while CS and OE are low, write on WE rising.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    assign sa_data = (!a_cs && !a_oe) ? mem_a[sa_addr[7:0]] : 'z;
    assign sb_data = (!b_cs && !b_oe) ? mem_b[sb_addr[7:0]] : 'z;

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = '0;
        mem_a[8'h10] = 16'hBEEF;
        forever begin
            @(posedge a_we);
            if (!a_cs) mem_a[sa_addr[7:0]] = sa_data;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = '0;
        mem_b[8'h10] = 16'hBEEF;
        forever begin
            @(posedge b_we);
            if (!b_cs) mem_b[sb_addr[7:0]] = sb_data;
        end
    end

    // Protocol watch: OE/WE overlap, bus contention during reads, bus driven while deselected.
    int viol_cnt = 0;
    always @(negedge clk) begin
        if (!a_oe && !a_we) viol_cnt++;
        if (!a_oe && (sa_data !== mem_a[sa_addr[7:0]])) viol_cnt++;
        if (a_cs && (sa_data !== 16'hzzzz)) viol_cnt++;
        if (!b_oe && !b_we) viol_cnt++;
        if (!b_oe && (sb_data !== mem_b[sb_addr[7:0]])) viol_cnt++;
        if (b_cs && (sb_data !== 16'hzzzz)) viol_cnt++;
    end

    // Selected-DUT view used by the access task.
    bit            cur_sel = 1'b0;
    logic          m_oe, m_we, m_cs, m_ack;
    logic [DW-1:0] m_data, m_rdata;
    logic [AW-1:0] m_saddr;
    always_comb begin
        if (cur_sel) begin
            m_oe = b_oe; m_we = b_we; m_cs = b_cs; m_ack = bus_b.ack;
            m_data = sb_data; m_rdata = bus_b.rdata; m_saddr = sb_addr;
        end else begin
            m_oe = a_oe; m_we = a_we; m_cs = a_cs; m_ack = bus_a.ack;
            m_data = sa_data; m_rdata = bus_a.rdata; m_saddr = sa_addr;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit sel, input logic r, input logic w,
                             input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (sel) begin
            bus_b.req = r; bus_b.we = w; bus_b.addr = ad; bus_b.wdata = wd;
        end else begin
            bus_a.req = r; bus_a.we = w; bus_a.addr = ad; bus_a.wdata = wd;
        end
    endtask

    // One access from IDLE; cycle 1 is the cycle after the accepting edge.
    task automatic run_access(input bit sel, input logic w, input logic [AW-1:0] ad,
                              input logic [DW-1:0] wd, input bit toggle,
                              output int ack_cyc, output int oe_low, output int we_low,
                              output logic [DW-1:0] rd, output int bus_bad);
        ack_cyc = -1; oe_low = 0; we_low = 0; rd = '0; bus_bad = 0;
        cur_sel = sel;
        @(negedge clk);
        drive_req(sel, 1'b1, w, ad, wd);
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (toggle)
                drive_req(sel, 1'b0, w, AW'(16'h0040 + $urandom_range(0, 16'h00BF)), DW'($urandom));
            else
                drive_req(sel, 1'b0, w, ad, wd);
            if (!m_oe) oe_low++;
            if (!m_we) we_low++;
            if (!m_cs && (m_saddr !== ad)) bus_bad++;
            if (w && !m_cs && (m_data !== wd)) bus_bad++;
            if (m_ack === 1'b1) begin
                ack_cyc = c;
                rd = m_rdata;
                break;
            end
        end
        $display("access dut=%0d %s addr=%h wdata=%h ack_cycle=%0d oe_low=%0d we_low=%0d rdata=%h",
                 sel, w ? "WR" : "RD", ad, wd, ack_cyc, oe_low, we_low, rd);
    endtask

    int            ack_c, oe_c, we_c, bad_c, ack1, ack2, idle_c;
    logic [DW-1:0] rd_v, rd1;

    initial begin
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_cs",    32'(a_cs), 32'd1);
        check_val("rst_oe",    32'(a_oe), 32'd1);
        check_val("rst_we",    32'(a_we), 32'd1);
        check_val("rst_busy",  32'(bus_a.busy), 32'd0);
        check_val("rst_ack",   32'(bus_a.ack), 32'd0);
        check_val("rst_rdata", 32'(bus_a.rdata), 32'd0);
        check_val("rst_saddr", 32'(sa_addr), 32'd0);
        check_val("rst_bus_z", 32'(sa_data === 16'hzzzz), 32'd1);
        $display("reset released");
        reset = 1'b0;

        // Read of the preloaded word.
        run_access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("rd_ack_cycle", 32'(ack_c), 32'd3);
        check_val("rd_oe_low",    32'(oe_c), 32'd2);
        check_val("rd_we_low",    32'(we_c), 32'd0);
        check_val("rd_data",      32'(rd_v), 32'h0000BEEF);

        // Write then read back.
        run_access(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("wr_ack_cycle", 32'(ack_c), 32'd6);
        check_val("wr_we_low",    32'(we_c), 32'd3);
        check_val("wr_oe_low",    32'(oe_c), 32'd0);
        check_val("wr_bus_bad",   32'(bad_c), 32'd0);
        check_val("wr_mem",       32'(mem_a[8'h20]), 32'h00001234);
        run_access(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("rb_data",      32'(rd_v), 32'h00001234);

        // Back-to-back with req held high: read 0x0010 then write 0x0021.
        cur_sel = 1'b0;
        ack1 = -1; ack2 = -1; idle_c = 0; rd1 = '0;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 5 && ack1 >= 0) drive_req(1'b0, 1'b0, 1'b1, 16'h0021, 16'hAAAA);
            if (bus_a.ack === 1'b1) begin
                if (ack1 < 0) begin
                    ack1 = c;
                    rd1  = bus_a.rdata;
                    drive_req(1'b0, 1'b1, 1'b1, 16'h0021, 16'hAAAA);
                end else begin
                    ack2 = c;
                    break;
                end
            end
            if (bus_a.busy !== 1'b1) idle_c++;
        end
        drive_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        $display("b2b read ack=%0d rdata=%h write ack=%0d idle_cycles=%0d", ack1, rd1, ack2, idle_c);
        check_val("b2b_rd_ack",  32'(ack1), 32'd3);
        check_val("b2b_rd_data", 32'(rd1), 32'h0000BEEF);
        check_val("b2b_wr_ack",  32'(ack2), 32'd10);
        check_val("b2b_idle",    32'(idle_c), 32'd1);
        check_val("b2b_mem",     32'(mem_a[8'h21]), 32'h0000AAAA);

        // Inputs toggling after acceptance must not disturb the access.
        run_access(1'b0, 1'b1, 16'h0022, 16'h9999, 1'b1, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("tog_wr_ack", 32'(ack_c), 32'd6);
        check_val("tog_wr_bad", 32'(bad_c), 32'd0);
        check_val("tog_wr_mem", 32'(mem_a[8'h22]), 32'h00009999);
        run_access(1'b0, 1'b0, 16'h0022, 16'h0000, 1'b1, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("tog_rd_bad",  32'(bad_c), 32'd0);
        check_val("tog_rd_data", 32'(rd_v), 32'h00009999);

        // Reset during WR_PULSE.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b1, 16'h0030, 16'h5555);
        @(negedge clk);
        check_val("mid_we_low", 32'(a_we), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_cs",    32'(a_cs), 32'd1);
        check_val("mid_oe",    32'(a_oe), 32'd1);
        check_val("mid_we",    32'(a_we), 32'd1);
        check_val("mid_bus_z", 32'(sa_data === 16'hzzzz), 32'd1);
        check_val("mid_busy",  32'(bus_a.busy), 32'd0);
        check_val("mid_ack",   32'(bus_a.ack), 32'd0);
        check_val("mid_rdata", 32'(bus_a.rdata), 32'd0);
        $display("reset applied during write pulse");
        reset = 1'b0;
        run_access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("post_rst_ack",  32'(ack_c), 32'd3);
        check_val("post_rst_data", 32'(rd_v), 32'h0000BEEF);

        // Zero wait states.
        run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("w0_rd_ack",  32'(ack_c), 32'd2);
        check_val("w0_rd_oe",   32'(oe_c), 32'd1);
        check_val("w0_rd_data", 32'(rd_v), 32'h0000BEEF);
        run_access(1'b1, 1'b1, 16'h0005, 16'h7777, 1'b0, ack_c, oe_c, we_c, rd_v, bad_c);
        check_val("w0_wr_ack",  32'(ack_c), 32'd4);
        check_val("w0_wr_we",   32'(we_c), 32'd1);
        check_val("w0_wr_bad",  32'(bad_c), 32'd0);
        check_val("w0_wr_mem",  32'(mem_b[8'h05]), 32'h00007777);

        repeat (2) @(negedge clk);
        check_val("protocol_violations", 32'(viol_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
